// File: rtl/id_stage_pipe_pkg.sv
// Shared ISA codes, control bundle and decode helpers for the ID stage.
// Latency: none, all items are constants or pure combinational functions.
// Backpressure: not applicable.
package id_stage_pipe_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JAL   = 4'h7;
  localparam logic [3:0] OP_JR    = 4'h8;
  localparam logic [3:0] OP_ANDI  = 4'h9;
  localparam logic [3:0] OP_ORI   = 4'hA;

  // ALU operations; R-type funct values map directly onto codes 0..7
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;

  // Destination register select
  localparam logic [1:0] RDST_RT   = 2'd0;
  localparam logic [1:0] RDST_RD   = 2'd1;
  localparam logic [1:0] RDST_LINK = 2'd2;

  localparam logic [2:0] REG_LINK = 3'd7;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [2:0] funct;
    logic [5:0] imm;
  } fields_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
  } ctrl_t;

  // Split an instruction into its (overlapping) fields
  function automatic fields_t instruction_decoder(input logic [15:0] instr);
    fields_t f;
    f.op    = instr[15:12];
    f.rs    = instr[11:9];
    f.rt    = instr[8:6];
    f.rd    = instr[5:3];
    f.funct = instr[2:0];
    f.imm   = instr[5:0];
    return f;
  endfunction

  // Main control decode; unknown opcodes decode as a no-op
  function automatic ctrl_t control_unit(input logic [3:0] op, input logic [2:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = RDST_RD;
        c.alu_op    = {1'b0, funct};
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_OR;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        c.branch    = 1'b1;
        c.branch_ne = 1'b1;
        c.alu_op    = ALU_SUB;
      end
      OP_JMP: c.jump = 1'b1;
      OP_JAL: begin
        c.jump      = 1'b1;
        c.link      = 1'b1;
        c.reg_write = 1'b1;
        c.reg_dst   = RDST_LINK;
      end
      OP_JR:   c.jump_reg = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile_bypass.sv
// 8 x XLEN register file, two combinational read ports with write-back bypass.
// Latency: reads 0 cycles; write lands on the rising edge.
// Backpressure: none, a write is accepted every cycle it is enabled.
module id_stage_pipe_regfile_bypass #(
  parameter int XLEN    = 16,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [XLEN-1:0] wr_dat,
  input  logic [2:0]      rd_addr1,
  input  logic [2:0]      rd_addr2,
  output logic [XLEN-1:0] rd_dat1,
  output logic [XLEN-1:0] rd_dat2
);

  logic [XLEN-1:0] mem [8];
  logic            wr_blocked;

  assign wr_blocked = (R0_ZERO != 0) && (wr_addr == 3'd0);

  // Storage: cleared on reset, written when write-back is enabled (r0 kept at 0 when hardwired)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (wr_en && !wr_blocked) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read ports: hardwired r0 beats bypass, bypass beats stored value
  always_comb begin
    rd_dat1 = mem[rd_addr1];
    rd_dat2 = mem[rd_addr2];
    if (wr_en && wr_addr == rd_addr1) rd_dat1 = wr_dat;
    if (wr_en && wr_addr == rd_addr2) rd_dat2 = wr_dat;
    if (R0_ZERO != 0 && rd_addr1 == 3'd0) rd_dat1 = '0;
    if (R0_ZERO != 0 && rd_addr2 == 3'd0) rd_dat2 = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: decodes if_instr, reads operands, drives the ID/EX register with hazard bubbles.
// Latency: 1 cycle from if_instr to id_* outputs.
// Backpressure: ex_stall holds ID/EX and raises stall_req; load-use inserts a bubble and stalls IF.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN       = 16,
  parameter int IMM_SIGNED = 1,
  parameter int R0_ZERO    = 1,
  parameter int HAZARD_EN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [15:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             ex_stall,
  input  logic             flush,
  input  logic             wb_reg_write,
  input  logic [2:0]       wb_write_reg,
  input  logic [XLEN-1:0]  wb_write_data,
  output logic             stall_req,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [2:0]       id_rs,
  output logic [2:0]       id_rt,
  output logic [2:0]       id_rd,
  output logic [XLEN-1:0]  id_imm,
  output logic [XLEN-1:0]  id_reg1,
  output logic [XLEN-1:0]  id_reg2,
  output logic             id_reg_write,
  output logic             id_mem_read,
  output logic             id_mem_write,
  output logic             id_mem_to_reg,
  output logic             id_alu_src,
  output logic             id_branch,
  output logic             id_branch_ne,
  output logic             id_jump,
  output logic             id_jump_reg,
  output logic             id_link,
  output logic [3:0]       id_alu_op,
  output logic [1:0]       id_reg_dst,
  output logic [CNT_W-1:0] hazard_cnt
);

  fields_t         dec;
  ctrl_t           dec_ctrl;
  ctrl_t           id_ctrl;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd_dat1;
  logic [XLEN-1:0] rd_dat2;
  logic [2:0]      id_write_reg;
  logic            id_write_r0;
  logic            load_use;

  assign dec      = instruction_decoder(if_instr);
  assign dec_ctrl = control_unit(dec.op, dec.funct);
  assign imm_ext  = (IMM_SIGNED != 0) ? {{(XLEN-6){dec.imm[5]}}, dec.imm}
                                      : {{(XLEN-6){1'b0}}, dec.imm};

  id_stage_pipe_regfile_bypass #(
    .XLEN    (XLEN),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_reg_write),
    .wr_addr  (wb_write_reg),
    .wr_dat   (wb_write_data),
    .rd_addr1 (dec.rs),
    .rd_addr2 (dec.rt),
    .rd_dat1  (rd_dat1),
    .rd_dat2  (rd_dat2)
  );

  // Destination of the instruction now in ID/EX, used to spot a load feeding the next instruction
  always_comb begin
    case (id_ctrl.reg_dst)
      RDST_RD:   id_write_reg = id_rd;
      RDST_LINK: id_write_reg = REG_LINK;
      default:   id_write_reg = id_rt;
    endcase
  end

  assign id_write_r0 = (R0_ZERO != 0) && (id_write_reg == 3'd0);
  assign load_use    = (HAZARD_EN != 0) && id_valid && id_ctrl.mem_read && if_valid &&
                       !id_write_r0 && ((id_write_reg == dec.rs) || (id_write_reg == dec.rt));

  // A flush redirects IF anyway, so it never asks IF to hold
  assign stall_req = !rst && !flush && (ex_stall || load_use);

  // ID/EX register: reset > flush > downstream stall > load-use bubble > normal advance
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_rs    <= '0;
      id_rt    <= '0;
      id_rd    <= '0;
      id_imm   <= '0;
      id_reg1  <= '0;
      id_reg2  <= '0;
      id_ctrl  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_ctrl  <= '0;
    end else if (!ex_stall) begin
      id_pc   <= if_pc;
      id_rs   <= dec.rs;
      id_rt   <= dec.rt;
      id_rd   <= dec.rd;
      id_imm  <= imm_ext;
      id_reg1 <= rd_dat1;
      id_reg2 <= rd_dat2;
      if (load_use) begin
        id_valid <= 1'b0;
        id_ctrl  <= '0;
      end else begin
        id_valid <= if_valid;
        id_ctrl  <= if_valid ? dec_ctrl : '0;
      end
    end
  end

  // Count inserted load-use bubbles, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt <= '0;
    end else if (!flush && !ex_stall && load_use && !(&hazard_cnt)) begin
      hazard_cnt <= hazard_cnt + CNT_W'(1);
    end
  end

  assign id_reg_write  = id_ctrl.reg_write;
  assign id_mem_read   = id_ctrl.mem_read;
  assign id_mem_write  = id_ctrl.mem_write;
  assign id_mem_to_reg = id_ctrl.mem_to_reg;
  assign id_alu_src    = id_ctrl.alu_src;
  assign id_branch     = id_ctrl.branch;
  assign id_branch_ne  = id_ctrl.branch_ne;
  assign id_jump       = id_ctrl.jump;
  assign id_jump_reg   = id_ctrl.jump_reg;
  assign id_link       = id_ctrl.link;
  assign id_alu_op     = id_ctrl.alu_op;
  assign id_reg_dst    = id_ctrl.reg_dst;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: main instance plus a zero-extend / 2-bit-counter instance.
// Latency: expected ID/EX state is queued before each edge and popped just after it.
// Backpressure: stall_req is checked against the hand-computed value before every edge.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic [15:0] if_pc = '0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [2:0]  wb_write_reg = '0;
  logic [15:0] wb_write_data = '0;

  logic        a_stall, a_vld, a_rw, a_mr, a_mw, a_m2r, a_as, a_br, a_bne, a_j, a_jr, a_lk;
  logic [15:0] a_pc, a_imm, a_r1, a_r2, a_cnt;
  logic [2:0]  a_rs, a_rt, a_rd;
  logic [3:0]  a_alu;
  logic [1:0]  a_dst;

  logic        b_stall, b_vld, b_rw, b_mr, b_mw, b_m2r, b_as, b_br, b_bne, b_j, b_jr, b_lk;
  logic [15:0] b_pc, b_imm, b_r1, b_r2;
  logic [1:0]  b_cnt;
  logic [2:0]  b_rs, b_rt, b_rd;
  logic [3:0]  b_alu;
  logic [1:0]  b_dst;

  always #5 clk = ~clk;

  id_stage_pipe u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_stall(ex_stall), .flush(flush), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .stall_req(a_stall), .id_valid(a_vld), .id_pc(a_pc), .id_rs(a_rs), .id_rt(a_rt),
    .id_rd(a_rd), .id_imm(a_imm), .id_reg1(a_r1), .id_reg2(a_r2),
    .id_reg_write(a_rw), .id_mem_read(a_mr), .id_mem_write(a_mw), .id_mem_to_reg(a_m2r),
    .id_alu_src(a_as), .id_branch(a_br), .id_branch_ne(a_bne), .id_jump(a_j),
    .id_jump_reg(a_jr), .id_link(a_lk), .id_alu_op(a_alu), .id_reg_dst(a_dst),
    .hazard_cnt(a_cnt)
  );

  id_stage_pipe #(.IMM_SIGNED(0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_stall(ex_stall), .flush(flush), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .stall_req(b_stall), .id_valid(b_vld), .id_pc(b_pc), .id_rs(b_rs), .id_rt(b_rt),
    .id_rd(b_rd), .id_imm(b_imm), .id_reg1(b_r1), .id_reg2(b_r2),
    .id_reg_write(b_rw), .id_mem_read(b_mr), .id_mem_write(b_mw), .id_mem_to_reg(b_m2r),
    .id_alu_src(b_as), .id_branch(b_br), .id_branch_ne(b_bne), .id_jump(b_j),
    .id_jump_reg(b_jr), .id_link(b_lk), .id_alu_op(b_alu), .id_reg_dst(b_dst),
    .hazard_cnt(b_cnt)
  );

  typedef struct {
    logic        vld;
    logic        chk_dat;
    logic [15:0] pc;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm, imm2, r1, r2, ctrl, cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Control vector {rw,mr,mw,m2r,asrc,br,bne,j,jr,link,alu[3:0],dst[1:0]}
  localparam logic [15:0] C_ADD  = 16'h8001;
  localparam logic [15:0] C_LW   = 16'hD800;
  localparam logic [15:0] C_ADDI = 16'h8800;
  localparam logic [15:0] C_SW   = 16'h2800;

  localparam logic [15:0] I_ADD123 = {4'h0, 3'd1, 3'd2, 3'd3, 3'd0};
  localparam logic [15:0] I_ADD554 = {4'h0, 3'd5, 3'd5, 3'd4, 3'd0};
  localparam logic [15:0] I_LW2    = {4'h2, 3'd5, 3'd2, 3'd0, 3'd1};
  localparam logic [15:0] I_ADD234 = {4'h0, 3'd2, 3'd3, 3'd4, 3'd0};
  localparam logic [15:0] I_LW0    = {4'h2, 3'd5, 3'd0, 3'd0, 3'd1};
  localparam logic [15:0] I_ADD013 = {4'h0, 3'd0, 3'd1, 3'd3, 3'd0};
  localparam logic [15:0] I_ADDI   = {4'h1, 3'd5, 3'd6, 3'd0, 3'd5};
  localparam logic [15:0] I_SW     = {4'h3, 3'd0, 3'd2, 3'd0, 3'd2};

  function automatic exp_t mk(input logic v, input logic [15:0] pc, input logic [2:0] rs,
                              input logic [2:0] rt, input logic [2:0] rd, input logic [15:0] imm,
                              input logic [15:0] imm2, input logic [15:0] r1, input logic [15:0] r2,
                              input logic [15:0] ctrl, input logic [15:0] cnt, input logic [1:0] cnt2);
    exp_t e;
    e.vld = v; e.chk_dat = 1'b1; e.pc = pc; e.rs = rs; e.rt = rt; e.rd = rd;
    e.imm = imm; e.imm2 = imm2; e.r1 = r1; e.r2 = r2; e.ctrl = ctrl; e.cnt = cnt; e.cnt2 = cnt2;
    return e;
  endfunction

  function automatic exp_t bub(input logic [15:0] cnt, input logic [1:0] cnt2);
    exp_t e;
    e = mk(1'b0, 16'h0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, cnt, cnt2);
    e.chk_dat = 1'b0;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check stall_req before the edge, queue the expected post-edge state, then advance
  task automatic step(input exp_t e, input logic st);
    @(negedge clk);
    cmp("stall_req", {31'd0, a_stall}, {31'd0, st});
    cmp("stall_req2", {31'd0, b_stall}, {31'd0, st});
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare the registered outputs of both instances right after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("id_valid", {31'd0, a_vld}, {31'd0, e.vld});
        cmp("id_valid2", {31'd0, b_vld}, {31'd0, e.vld});
        cmp("ctrl", {16'd0, a_rw, a_mr, a_mw, a_m2r, a_as, a_br, a_bne, a_j, a_jr, a_lk, a_alu, a_dst},
            {16'd0, e.ctrl});
        cmp("ctrl2", {16'd0, b_rw, b_mr, b_mw, b_m2r, b_as, b_br, b_bne, b_j, b_jr, b_lk, b_alu, b_dst},
            {16'd0, e.ctrl});
        cmp("hazard_cnt", {16'd0, a_cnt}, {16'd0, e.cnt});
        cmp("hazard_cnt2", {30'd0, b_cnt}, {30'd0, e.cnt2});
        if (e.chk_dat) begin
          cmp("id_pc", {16'd0, a_pc}, {16'd0, e.pc});
          cmp("id_fields", {23'd0, a_rs, a_rt, a_rd}, {23'd0, e.rs, e.rt, e.rd});
          cmp("id_imm", {16'd0, a_imm}, {16'd0, e.imm});
          cmp("id_imm2", {16'd0, b_imm}, {16'd0, e.imm2});
          cmp("id_reg1", {16'd0, a_r1}, {16'd0, e.r1});
          cmp("id_reg2", {16'd0, a_r2}, {16'd0, e.r2});
          cmp("id_regs2", {b_r1, b_r2}, {e.r1, e.r2});
          cmp("id_pc_fields2", {7'd0, b_pc, b_rs, b_rt, b_rd}, {7'd0, e.pc, e.rs, e.rt, e.rd});
        end
      end
    end
  end

  exp_t r_zero, r_lw, r_add;
  logic [15:0] ca [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
  logic [1:0]  cb [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    r_zero = mk(1'b0, 16'h0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 2'd0);

    // Reset for two cycles with an ADD waiting, then it issues
    rst = 1'b1; if_valid = 1'b1; if_instr = I_ADD123; if_pc = 16'h0010;
    step(r_zero, 1'b0);
    step(r_zero, 1'b0);
    rst = 1'b0;
    step(mk(1'b1, 16'h0010, 3'd1, 3'd2, 3'd3, 16'h0018, 16'h0018, 16'h0, 16'h0, C_ADD, 16'd0, 2'd0), 1'b0);

    // Write-back bypass of r5 in the same cycle; imm 6'b100000 extension
    if_instr = I_ADD554; if_pc = 16'h0012;
    wb_reg_write = 1'b1; wb_write_reg = 3'd5; wb_write_data = 16'h1234;
    step(mk(1'b1, 16'h0012, 3'd5, 3'd5, 3'd4, 16'hFFE0, 16'h0020, 16'h1234, 16'h1234, C_ADD, 16'd0, 2'd0), 1'b0);
    wb_reg_write = 1'b0;

    // Load-use: LW r2 then ADD reading r2 -> one bubble
    if_instr = I_LW2; if_pc = 16'h0014;
    step(mk(1'b1, 16'h0014, 3'd5, 3'd2, 3'd0, 16'h0001, 16'h0001, 16'h1234, 16'h0, C_LW, 16'd0, 2'd0), 1'b0);
    if_instr = I_ADD234; if_pc = 16'h0016;
    step(bub(16'd1, 2'd1), 1'b1);
    step(mk(1'b1, 16'h0016, 3'd2, 3'd3, 3'd4, 16'hFFE0, 16'h0020, 16'h0, 16'h0, C_ADD, 16'd1, 2'd1), 1'b0);

    // Load into r0 creates no hazard; write to r0 is dropped and bypass ignored
    if_instr = I_LW0; if_pc = 16'h0018;
    step(mk(1'b1, 16'h0018, 3'd5, 3'd0, 3'd0, 16'h0001, 16'h0001, 16'h1234, 16'h0, C_LW, 16'd1, 2'd1), 1'b0);
    if_instr = I_ADD013; if_pc = 16'h001A;
    wb_reg_write = 1'b1; wb_write_reg = 3'd0; wb_write_data = 16'hBEEF;
    step(mk(1'b1, 16'h001A, 3'd0, 3'd1, 3'd3, 16'h0018, 16'h0018, 16'h0, 16'h0, C_ADD, 16'd1, 2'd1), 1'b0);
    wb_reg_write = 1'b0;

    // Downstream stall for three cycles with a flush in the middle one
    if_instr = I_ADDI; if_pc = 16'h001C;
    r_add = mk(1'b1, 16'h001C, 3'd5, 3'd6, 3'd0, 16'h0005, 16'h0005, 16'h1234, 16'h0, C_ADDI, 16'd1, 2'd1);
    step(r_add, 1'b0);
    if_instr = I_SW; if_pc = 16'h001E; ex_stall = 1'b1;
    step(r_add, 1'b1);
    flush = 1'b1;
    step(bub(16'd1, 2'd1), 1'b0);
    flush = 1'b0;
    step(bub(16'd1, 2'd1), 1'b1);
    ex_stall = 1'b0;
    step(mk(1'b1, 16'h001E, 3'd0, 3'd2, 3'd0, 16'h0002, 16'h0002, 16'h0, 16'h0, C_SW, 16'd1, 2'd1), 1'b0);

    // Three more load-use bubbles: 2-bit counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      if_instr = I_LW2; if_pc = 16'h0020;
      step(mk(1'b1, 16'h0020, 3'd5, 3'd2, 3'd0, 16'h0001, 16'h0001, 16'h1234, 16'h0, C_LW, ca[k], cb[k]), 1'b0);
      if_instr = I_ADD234; if_pc = 16'h0022;
      step(bub(ca[k+1], cb[k+1]), 1'b1);
      step(mk(1'b1, 16'h0022, 3'd2, 3'd3, 3'd4, 16'hFFE0, 16'h0020, 16'h0, 16'h0, C_ADD, ca[k+1], cb[k+1]), 1'b0);
    end

    // Flush beats a pending load-use: no stall, counter unchanged
    if_instr = I_LW2; if_pc = 16'h0024;
    r_lw = mk(1'b1, 16'h0024, 3'd5, 3'd2, 3'd0, 16'h0001, 16'h0001, 16'h1234, 16'h0, C_LW, 16'd4, 2'd3);
    step(r_lw, 1'b0);
    if_instr = I_ADD234; if_pc = 16'h0026; flush = 1'b1;
    step(bub(16'd4, 2'd3), 1'b0);
    flush = 1'b0;
    r_add = mk(1'b1, 16'h0026, 3'd2, 3'd3, 3'd4, 16'hFFE0, 16'h0020, 16'h0, 16'h0, C_ADD, 16'd4, 2'd3);
    step(r_add, 1'b0);

    // Reset while stalled clears everything
    ex_stall = 1'b1;
    step(r_add, 1'b1);
    rst = 1'b1;
    step(r_zero, 1'b0);
    rst = 1'b0; ex_stall = 1'b0; if_valid = 1'b0;

    @(posedge clk);
    #3;
    cmp("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
